// File: rtl/spi_ram_pkg.sv
// ============================================================================
// spi_ram_pkg : shared types and widths for the SPI RAM command stage
// Revision    : 1.0
// ============================================================================
`default_nettype none

package spi_ram_pkg;

  localparam int FRAME_W = 10;
  localparam int DATA_W  = 8;

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_t;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    TX_HOLD = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/spi_ram_if.sv
// ============================================================================
// spi_ram_if : frame/readback bus between the SPI slave and the RAM stage
// Revision   : 1.0
// ============================================================================
`default_nettype none

interface spi_ram_if;
  import spi_ram_pkg::*;

  logic [FRAME_W-1:0] rx_data;
  logic               rx_valid;
  logic [DATA_W-1:0]  tx_data;
  logic               tx_valid;
  logic               cmd_err;

  // master = SPI slave side (issues frames), slave = RAM command stage
  modport master (output rx_data, output rx_valid,
                  input  tx_data, input  tx_valid, input cmd_err);
  modport slave  (input  rx_data, input  rx_valid,
                  output tx_data, output tx_valid, output cmd_err);

endinterface

`default_nettype wire

// File: rtl/spi_ram_mem.sv
// ============================================================================
// spi_ram_mem : single-port byte array, synchronous write, registered read
// Revision    : 1.0
// ============================================================================
`default_nettype none

module spi_ram_mem #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;

  // Read register only moves on a read so the byte stays put while held
  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem_q[addr];
  end

  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

`default_nettype wire

// File: rtl/spi_ram_ctrl.sv
// ============================================================================
// spi_ram_ctrl : decodes 10-bit SPI frames into address/write/read commands
// Optional     : SPI_RAM_ADDR_AUTOINC_EN (post-access address increment)
// Revision     : 1.0
// ============================================================================
`default_nettype none

module spi_ram_ctrl
  import spi_ram_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input logic       clk,
  input logic       rst,
  spi_ram_if.slave  bus
);

  cmd_t                 cmd;
  logic [DATA_W-1:0]    payload;

  state_t               state_q,       state_d;
  logic [ADDR_SIZE-1:0] wr_addr_q,     wr_addr_d;
  logic [ADDR_SIZE-1:0] rd_addr_q,     rd_addr_d;
  logic                 wr_addr_vld_q, wr_addr_vld_d;
  logic                 rd_addr_vld_q, rd_addr_vld_d;
  logic                 cmd_err_q,     cmd_err_d;

  logic [ADDR_SIZE-1:0] wr_eff;
  logic [ADDR_SIZE-1:0] rd_eff;
  logic [ADDR_SIZE-1:0] mem_addr;
  logic                 mem_we;
  logic                 mem_re;
  logic [DATA_W-1:0]    mem_rdata;

  assign cmd     = cmd_t'(bus.rx_data[FRAME_W-1:DATA_W]);
  assign payload = bus.rx_data[DATA_W-1:0];

  // Data commands issued before their address load fall back to location 0
  assign wr_eff = wr_addr_vld_q ? wr_addr_q : '0;
  assign rd_eff = rd_addr_vld_q ? rd_addr_q : '0;

  always_comb begin
    state_d       = state_q;
    wr_addr_d     = wr_addr_q;
    rd_addr_d     = rd_addr_q;
    wr_addr_vld_d = wr_addr_vld_q;
    rd_addr_vld_d = rd_addr_vld_q;
    cmd_err_d     = 1'b0;
    mem_we        = 1'b0;
    mem_re        = 1'b0;
    mem_addr      = wr_eff;
    if (bus.rx_valid) begin
      state_d = (cmd == CMD_RD_DATA) ? TX_HOLD : IDLE;
      case (cmd)
        CMD_WR_ADDR: begin
          wr_addr_d     = payload[ADDR_SIZE-1:0];
          wr_addr_vld_d = 1'b1;
        end
        CMD_WR_DATA: begin
          mem_we    = 1'b1;
          mem_addr  = wr_eff;
          cmd_err_d = !wr_addr_vld_q;
`ifdef SPI_RAM_ADDR_AUTOINC_EN
          wr_addr_d = wr_eff + ADDR_SIZE'(1);
`endif
        end
        CMD_RD_ADDR: begin
          rd_addr_d     = payload[ADDR_SIZE-1:0];
          rd_addr_vld_d = 1'b1;
        end
        default: begin
          mem_re    = 1'b1;
          mem_addr  = rd_eff;
          cmd_err_d = !rd_addr_vld_q;
`ifdef SPI_RAM_ADDR_AUTOINC_EN
          rd_addr_d = rd_eff + ADDR_SIZE'(1);
`endif
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      wr_addr_q     <= '0;
      rd_addr_q     <= '0;
      wr_addr_vld_q <= 1'b0;
      rd_addr_vld_q <= 1'b0;
      cmd_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_addr_q     <= wr_addr_d;
      rd_addr_q     <= rd_addr_d;
      wr_addr_vld_q <= wr_addr_vld_d;
      rd_addr_vld_q <= rd_addr_vld_d;
      cmd_err_q     <= cmd_err_d;
    end
  end

  spi_ram_mem #(
    .DEPTH  (MEM_DEPTH),
    .ADDR_W (ADDR_SIZE),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .re    (mem_re),
    .addr  (mem_addr),
    .wdata (payload),
    .rdata (mem_rdata)
  );

  // The memory read register has no reset, so gate it with the FSM state
  assign bus.tx_valid = (state_q == TX_HOLD);
  assign bus.tx_data  = (state_q == TX_HOLD) ? mem_rdata : '0;
  assign bus.cmd_err  = cmd_err_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_ram_ctrl.sv
// ============================================================================
// tb_spi_ram_ctrl : randomized self-checking bench for spi_ram_ctrl
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_spi_ram_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_ram_if bus ();

  spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a plain byte array plus the command rules
  logic [7:0] m_mem   [256];
  bit         m_known [256];
  logic [7:0] m_wa, m_ra, m_tx;
  bit         m_wv, m_rv, m_txv, m_err, m_tx_known;

  task automatic model_reset();
    m_wa = 0; m_ra = 0; m_wv = 0; m_rv = 0;
    m_txv = 0; m_err = 0; m_tx = 0; m_tx_known = 1;
  endtask

  task automatic model_apply(input bit v, input logic [1:0] c, input logic [7:0] p);
    logic [7:0] a;
    m_err = 0;
    if (v) begin
      m_txv = (c == 2'd3);
      case (c)
        2'd0: begin m_wa = p; m_wv = 1; end
        2'd1: begin
          a = m_wv ? m_wa : 8'd0;
          m_err = !m_wv;
          m_mem[a] = p; m_known[a] = 1;
`ifdef SPI_RAM_ADDR_AUTOINC_EN
          m_wa = a + 8'd1;
`endif
        end
        2'd2: begin m_ra = p; m_rv = 1; end
        default: begin
          a = m_rv ? m_ra : 8'd0;
          m_err = !m_rv;
          m_tx = m_mem[a]; m_tx_known = m_known[a];
`ifdef SPI_RAM_ADDR_AUTOINC_EN
          m_ra = a + 8'd1;
`endif
        end
      endcase
    end
  endtask

  // Present one frame for one clock; outputs are sampled 1 ns after the edge
  task automatic step(input bit v, input logic [1:0] c, input logic [7:0] p);
    bus.rx_valid = v;
    bus.rx_data  = {c, p};
    @(posedge clk);
    #1;
    model_apply(v, c, p);
    bus.rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    n_tests++;
    if (bus.tx_valid !== 1'b0 || bus.tx_data !== 8'h00 || bus.cmd_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: tx_valid=%b tx_data=%h cmd_err=%b required 0/00/0",
               bus.tx_valid, bus.tx_data, bus.cmd_err);
    end
    rst = 1'b0;
  endtask

  task automatic test_fill();
    for (int a = 0; a < 256; a++) begin
      step(1, 2'd0, 8'(a));
      step(1, 2'd1, 8'($urandom));
      n_tests++;
      if (bus.cmd_err !== 1'b0) begin
        n_fail++;
        $display("FAIL fill_err: addr %0d cmd_err=%b required 0", a, bus.cmd_err);
      end
    end
  endtask

  task automatic test_write_read();
    logic [9:0] fr [4];
    fr[0] = 10'h010; fr[1] = 10'h1AB; fr[2] = 10'h210; fr[3] = 10'h300;
    for (int i = 0; i < 4; i++) begin
      step(1, fr[i][9:8], fr[i][7:0]);
      n_tests++;
      if (bus.cmd_err !== 1'b0) begin
        n_fail++;
        $display("FAIL wr_rd_err: frame %0d cmd_err=%b required 0", i, bus.cmd_err);
      end
    end
    n_tests++;
    if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'hAB) begin
      n_fail++;
      $display("FAIL wr_rd_data: tx_valid=%b tx_data=%h required 1/ab", bus.tx_valid, bus.tx_data);
    end
  endtask

  task automatic test_hold_clear();
    int bad = 0;
    for (int i = 0; i < 20; i++) begin
      step(0, 2'd0, 8'h00);
      if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'hAB) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL hold: %0d idle cycles lost tx_valid/tx_data, required 0", bad);
    end
    step(1, 2'd2, 8'h00);
    n_tests++;
    if (bus.tx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL clear: tx_valid=%b required 0", bus.tx_valid);
    end
  endtask

  task automatic test_order_err();
    @(negedge clk);
    rst = 1'b1;
    #1;
    rst = 1'b0;
    model_reset();
    step(1, 2'd3, 8'h00);
    n_tests++;
    if (bus.cmd_err !== 1'b1 || bus.tx_valid !== 1'b1 || bus.tx_data !== m_tx) begin
      n_fail++;
      $display("FAIL rd_noaddr: cmd_err=%b tx_valid=%b tx_data=%h required 1/1/%h",
               bus.cmd_err, bus.tx_valid, bus.tx_data, m_tx);
    end
    step(1, 2'd1, 8'h55);
    n_tests++;
    if (bus.cmd_err !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_noaddr: cmd_err=%b required 1", bus.cmd_err);
    end
    step(0, 2'd0, 8'h00);
    n_tests++;
    if (bus.cmd_err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_pulse: cmd_err=%b required 0", bus.cmd_err);
    end
    step(1, 2'd2, 8'h00);
    step(1, 2'd3, 8'h00);
    n_tests++;
    if (bus.tx_data !== 8'h55 || bus.cmd_err !== 1'b0) begin
      n_fail++;
      $display("FAIL mem0: tx_data=%h cmd_err=%b required 55/0", bus.tx_data, bus.cmd_err);
    end
  endtask

  task automatic test_autoinc();
    logic [7:0] exp1;
`ifdef SPI_RAM_ADDR_AUTOINC_EN
    exp1 = 8'h11;
`else
    exp1 = 8'h22;
`endif
    step(1, 2'd0, 8'hFF);
    step(1, 2'd1, 8'h11);
    step(1, 2'd1, 8'h22);
    step(1, 2'd2, 8'hFF);
    step(1, 2'd3, 8'h00);
    n_tests++;
    if (bus.tx_data !== exp1 || bus.tx_data !== m_tx) begin
      n_fail++;
      $display("FAIL autoinc_rd1: tx_data=%h required %h", bus.tx_data, exp1);
    end
    step(1, 2'd3, 8'h00);
    n_tests++;
    if (bus.tx_data !== 8'h22 || bus.tx_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL autoinc_rd2: tx_data=%h tx_valid=%b required 22/1", bus.tx_data, bus.tx_valid);
    end
  endtask

  task automatic test_reset_mid();
    step(1, 2'd2, 8'h10);
    step(1, 2'd3, 8'h00);
    n_tests++;
    if (bus.tx_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_rst: tx_valid=%b required 1", bus.tx_valid);
    end
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if (bus.tx_valid !== 1'b0 || bus.tx_data !== 8'h00) begin
      n_fail++;
      $display("FAIL async_rst: tx_valid=%b tx_data=%h required 0/00", bus.tx_valid, bus.tx_data);
    end
    #1;
    rst = 1'b0;
    model_reset();
    step(1, 2'd3, 8'h00);
    n_tests++;
    if (bus.cmd_err !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_clears_vld: cmd_err=%b required 1", bus.cmd_err);
    end
  endtask

  task automatic test_back_to_back();
    int bad = 0;
    step(1, 2'd2, 8'($urandom));
    for (int i = 0; i < 16; i++) begin
      step(1, 2'd3, 8'h00);
      if (bus.tx_valid !== 1'b1 || bus.tx_data !== m_tx) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL back_to_back: %0d reads wrong or tx_valid dropped, required 0", bad);
    end
  endtask

  task automatic test_random();
    bit v;
    logic [1:0] c;
    logic [7:0] p;
    for (int i = 0; i < 500; i++) begin
      v = ($urandom_range(0, 3) != 0);
      c = 2'($urandom_range(0, 3));
      p = 8'($urandom);
      step(v, c, p);
      n_tests++;
      if (bus.tx_valid !== m_txv || bus.cmd_err !== m_err) begin
        n_fail++;
        $display("FAIL rand_ctl[%0d]: tx_valid=%b cmd_err=%b required %b/%b",
                 i, bus.tx_valid, bus.cmd_err, m_txv, m_err);
      end
      if (m_txv && m_tx_known) begin
        n_tests++;
        if (bus.tx_data !== m_tx) begin
          n_fail++;
          $display("FAIL rand_data[%0d]: tx_data=%h required %h", i, bus.tx_data, m_tx);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin m_mem[i] = 8'h00; m_known[i] = 0; end
    bus.rx_valid = 1'b0;
    bus.rx_data  = '0;
    test_reset();
    test_fill();
    test_write_read();
    test_hold_clear();
    test_order_err();
    test_autoinc();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
